// File: rtl/spi_tx_pkg.sv
// rtl/spi_tx_pkg.sv - state encoding and shared constants for the SPI FIFO transmitter
package spi_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_LOW,
    ST_HIGH,
    ST_GAP
  } state_t;

  localparam int SENT_COUNT_WIDTH = 16;

  localparam logic IDLE_CS_N = 1'b1;
  localparam logic IDLE_SCLK = 1'b0;
  localparam logic IDLE_SDO  = 1'b0;

endpackage

// File: rtl/spi_fifo_transmitter_if.sv
// rtl/spi_fifo_transmitter_if.sv - FIFO read port and SPI pin bundle
interface spi_fifo_transmitter_if #(
  parameter int WIDTH = 8
);

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_rd_en;
  logic             sclk;
  logic             sdo;
  logic             cs_n;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en,
    output sclk,
    output sdo,
    output cs_n
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en,
    input  sclk,
    input  sdo,
    input  cs_n
  );

endinterface

// File: rtl/spi_fifo_transmitter_shiftloadreg.sv
// rtl/spi_fifo_transmitter_shiftloadreg.sv - parallel-load, shift-left register
module spi_fifo_transmitter_shiftloadreg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_in,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_q_msb
);

  logic [WIDTH-1:0] r_q;

  // Load has priority over shift; the serial input fills from the LSB end.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_en) begin
      r_q <= {r_q[WIDTH-2:0], i_in};
    end
  end

  assign o_q_msb = r_q[WIDTH-1];

endmodule

// File: rtl/spi_fifo_transmitter.sv
// rtl/spi_fifo_transmitter.sv - drains FIFO words and sends each as one mode-0 SPI frame, MSB first
module spi_fifo_transmitter
  import spi_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HALF  = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  spi_fifo_transmitter_if.master      io_bus,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [SENT_COUNT_WIDTH-1:0] o_sent_count
);

  localparam int DIV_W = $clog2(HALF) + 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(WIDTH - 1);

  state_t                      r_state;
  state_t                      w_next;
  logic [DIV_W-1:0]            r_div_cnt;
  logic [BIT_W-1:0]            r_bit_cnt;
  logic [SENT_COUNT_WIDTH-1:0] r_sent_count;
  logic                        w_div_end;
  logic                        w_shift;
  logic                        w_first_gap;
  logic                        w_q_msb;

  assign w_div_end   = (r_div_cnt == DIV_LAST);
  assign w_shift     = (r_state == ST_HIGH) && w_div_end && (r_bit_cnt != '0);
  assign w_first_gap = (r_state == ST_GAP) && (r_div_cnt == '0);

  spi_fifo_transmitter_shiftloadreg #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .i_clk   (i_clk),
    .i_rst   (!i_rst_n),
    .i_load  (r_state == ST_LOAD),
    .i_en    (w_shift),
    .i_in    (1'b0),
    .i_d     (io_bus.fifo_data),
    .o_q_msb (w_q_msb)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_en && !io_bus.fifo_empty) w_next = ST_FETCH;
      ST_FETCH: w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_LOW;
      ST_LOW:   if (w_div_end) w_next = ST_HIGH;
      ST_HIGH:  if (w_div_end) w_next = (r_bit_cnt == '0) ? ST_GAP : ST_LOW;
      ST_GAP:   if (w_div_end) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // The divider restarts on every timed-state boundary so each phase lasts HALF cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_sent_count <= '0;
    end else begin
      case (r_state)
        ST_LOW, ST_HIGH, ST_GAP: r_div_cnt <= w_div_end ? '0 : r_div_cnt + 1'b1;
        default:                 r_div_cnt <= '0;
      endcase
      if (r_state == ST_LOAD) begin
        r_bit_cnt <= BIT_TOP;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end
      if (w_first_gap) begin
        r_sent_count <= r_sent_count + 1'b1;
      end
    end
  end

  always_comb begin
    io_bus.cs_n       = IDLE_CS_N;
    io_bus.sclk       = IDLE_SCLK;
    io_bus.sdo        = IDLE_SDO;
    io_bus.fifo_rd_en = 1'b0;
    o_busy            = (r_state != ST_IDLE);
    o_done            = 1'b0;
    case (r_state)
      ST_FETCH: io_bus.fifo_rd_en = 1'b1;
      ST_LOW: begin
        io_bus.cs_n = 1'b0;
        io_bus.sdo  = w_q_msb;
      end
      ST_HIGH: begin
        io_bus.cs_n = 1'b0;
        io_bus.sclk = 1'b1;
        io_bus.sdo  = w_q_msb;
      end
      ST_GAP:  o_done = w_first_gap;
      default: ;
    endcase
  end

  assign o_sent_count = r_sent_count;

endmodule

// File: tb/tb_spi_fifo_transmitter.sv
// tb/tb_spi_fifo_transmitter.sv - self-checking bench for spi_fifo_transmitter
module tb_spi_fifo_transmitter;

  localparam int W         = 8;
  localparam int H         = 2;
  localparam int FRAME_LOW = 2 * H * W;
  localparam int GAP_B2B   = H + 3;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_frame;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        en2   = 1'b0;
  logic        busy, done, busy2, done2;
  logic [15:0] sent_count, sent_count2;
  int          total = 0;
  int          bad   = 0;

  spi_fifo_transmitter_if #(.WIDTH(W)) bus ();
  spi_fifo_transmitter_if #(.WIDTH(2)) bus2 ();

  spi_fifo_transmitter #(.WIDTH(W), .HALF(H)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .io_bus       (bus),
    .o_busy       (busy),
    .o_done       (done),
    .o_sent_count (sent_count)
  );

  spi_fifo_transmitter #(.WIDTH(2), .HALF(1)) dut2 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en2),
    .io_bus       (bus2),
    .o_busy       (busy2),
    .o_done       (done2),
    .o_sent_count (sent_count2)
  );

  // FIFO feeding the main instance: data appears the cycle after a pop.
  logic [W-1:0] mem [0:255];
  int wr_ptr = 0, rd_ptr = 0, underflow = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      if (wr_ptr == rd_ptr) underflow++;
      bus.fifo_data <= mem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int wr2 = 0, rd2 = 0;
  assign bus2.fifo_empty = (wr2 == rd2);
  assign bus2.fifo_data  = 2'b10;
  always @(posedge clk) if (bus2.fifo_rd_en) rd2 <= rd2 + 1;

  // Pin-level observer: rebuilds each frame from sdo at sclk rises.
  int rd_pulses = 0, done_pulses = 0, sdo_bad = 0, idle_bad = 0, done_bad = 0;
  int low_len = 0, high_len = 0, rises = 0;
  logic [W-1:0] shreg = '0;
  logic p_cs = 1'b1, p_sclk = 1'b0, p_sdo = 1'b0;
  logic [W-1:0] rx_q[$];
  int len_q[$], rise_q[$], gap_q[$];

  always @(negedge clk) begin
    if (bus.fifo_rd_en) rd_pulses++;
    if (done) begin
      done_pulses++;
      if (!(bus.cs_n && !p_cs)) done_bad++;
    end
    if (!bus.cs_n) begin
      if (p_cs) begin
        gap_q.push_back(high_len);
        low_len = 0;
        rises   = 0;
        shreg   = '0;
      end else if (bus.sdo != p_sdo && !(p_sclk && !bus.sclk)) begin
        sdo_bad++;
      end
      low_len++;
      if (bus.sclk && !p_sclk) begin
        shreg = {shreg[W-2:0], bus.sdo};
        rises++;
      end
      high_len = 0;
    end else begin
      if (!p_cs) begin
        rx_q.push_back(shreg);
        len_q.push_back(low_len);
        rise_q.push_back(rises);
      end
      if (bus.sclk || bus.sdo) idle_bad++;
      high_len++;
    end
    p_cs   = bus.cs_n;
    p_sclk = bus.sclk;
    p_sdo  = bus.sdo;
  end

  int cyc2 = 0, low2 = 0, rises2 = 0, last_rise2 = -1, period_bad2 = 0, done2_cnt = 0;
  logic [1:0] bits2 = '0;
  logic p_sclk2 = 1'b0;
  always @(negedge clk) begin
    cyc2++;
    if (done2) done2_cnt++;
    if (!bus2.cs_n) low2++;
    if (bus2.sclk && !p_sclk2) begin
      bits2 = {bits2[0], bus2.sdo};
      rises2++;
      if (last_rise2 >= 0 && cyc2 - last_rise2 != 2) period_bad2++;
      last_rise2 = cyc2;
    end
    p_sclk2 = bus2.sclk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    mem[wr_ptr % 256] = d;
    wr_ptr++;
  endtask

  task automatic clear_q();
    rx_q.delete();
    len_q.delete();
    rise_q.delete();
    gap_q.delete();
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while ((busy || wr_ptr != rd_ptr) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(name, n < 5000, 1);
  endtask

  task automatic chk_frame(input string name, input logic [W-1:0] exp);
    chk({name, "_present"}, rx_q.size() > 0, 1);
    if (rx_q.size() > 0) begin
      chk({name, "_data"}, rx_q.pop_front(), exp);
      chk({name, "_low"}, len_q.pop_front(), FRAME_LOW);
      chk({name, "_rises"}, rise_q.pop_front(), W);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    vec_t         vecs[6];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] d;
    int           base_rd, base_done, base_cnt, n, gap_bad;

    vecs[0] = '{data: 8'h3C, exp_frame: 8'h3C};
    vecs[1] = '{data: 8'hC3, exp_frame: 8'hC3};
    vecs[2] = '{data: 8'h00, exp_frame: 8'h00};
    vecs[3] = '{data: 8'hFF, exp_frame: 8'hFF};
    vecs[4] = '{data: 8'h80, exp_frame: 8'h80};
    vecs[5] = '{data: 8'h01, exp_frame: 8'h01};

    repeat (3) @(negedge clk);
    chk("rst_cs_n", bus.cs_n, 1);
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_sdo", bus.sdo, 0);
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", sent_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word: exact latency from request to first edge.
    push(8'hA5);
    en = 1'b1;
    @(negedge clk);
    chk("t1_rd_en", bus.fifo_rd_en, 1);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_load_rd_en", bus.fifo_rd_en, 0);
    chk("t1_load_cs_n", bus.cs_n, 1);
    @(negedge clk);
    chk("t1_cs_fall", bus.cs_n, 0);
    chk("t1_msb", bus.sdo, 1);
    chk("t1_sclk_low", bus.sclk, 0);
    repeat (H) @(negedge clk);
    chk("t1_first_rise", bus.sclk, 1);
    wait_quiet("t1_quiet");
    chk_frame("t1", 8'hA5);
    chk("t1_rd_pulses", rd_pulses, 1);
    chk("t1_done_pulses", done_pulses, 1);
    chk("t1_count", sent_count, 1);

    // Table of back-to-back words.
    clear_q();
    base_rd = rd_pulses;
    foreach (vecs[i]) push(vecs[i].data);
    wait_quiet("t2_quiet");
    for (int i = 0; i < 6; i++) begin
      chk_frame($sformatf("t2_v%0d", i), vecs[i].exp_frame);
      if (i > 0) chk($sformatf("t2_gap%0d", i), gap_q[i], GAP_B2B);
    end
    chk("t2_count", sent_count, 7);
    chk("t2_rd", rd_pulses - base_rd, 6);
    chk("t2_empty", bus.fifo_empty, 1);

    // Random words at random spacing against an in-order queue model.
    clear_q();
    exp_q.delete();
    base_cnt = sent_count;
    for (int i = 0; i < 20; i++) begin
      d = W'($urandom);
      push(d);
      exp_q.push_back(d);
      repeat ($urandom_range(0, 45)) @(negedge clk);
    end
    wait_quiet("t3_quiet");
    chk("t3_frames", rx_q.size(), 20);
    gap_bad = 0;
    foreach (gap_q[i]) if (gap_q[i] < GAP_B2B) gap_bad++;
    chk("t3_gap_bad", gap_bad, 0);
    n = 0;
    while (exp_q.size() > 0) begin
      chk_frame($sformatf("t3_f%0d", n), exp_q.pop_front());
      n++;
    end
    chk("t3_count", sent_count - base_cnt, 20);

    // Empty FIFO with enable held: nothing may move.
    base_rd = rd_pulses;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || !bus.cs_n || bus.sclk || bus.fifo_rd_en) n++;
    end
    chk("t4_idle_viol", n, 0);
    chk("t4_rd", rd_pulses - base_rd, 0);

    // Enable dropped during the third bit of the first of two queued words.
    clear_q();
    base_rd   = rd_pulses;
    base_done = done_pulses;
    push(8'h96);
    push(8'h69);
    n = 0;
    while (bus.cs_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_start", n < 50, 1);
    repeat (2 * 2 * H + 1) @(negedge clk);
    en = 1'b0;
    n = 0;
    while (done_pulses == base_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    chk("t5_done", done_pulses - base_done, 1);
    chk("t5_rd", rd_pulses - base_rd, 1);
    chk_frame("t5_first", 8'h96);
    chk("t5_left", wr_ptr - rd_ptr, 1);
    chk("t5_busy", busy, 0);
    en = 1'b1;
    wait_quiet("t5_drain");
    chk_frame("t5_second", 8'h69);

    // Asynchronous reset in the high phase of bit 4, then a clean frame.
    clear_q();
    push(8'hE7);
    n = 0;
    while (bus.cs_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_start", n < 50, 1);
    repeat (3 * 2 * H + H) @(negedge clk);
    chk("t6_in_high", bus.sclk, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cs_n", bus.cs_n, 1);
    chk("t6_sclk", bus.sclk, 0);
    chk("t6_sdo", bus.sdo, 0);
    chk("t6_busy", busy, 0);
    chk("t6_count", sent_count, 0);
    chk("t6_rd_en", bus.fifo_rd_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_q();
    push(8'h5A);
    wait_quiet("t6_quiet");
    chk_frame("t6_after", 8'h5A);
    chk("t6_count_after", sent_count, 1);

    // Narrowest configuration: WIDTH=2, HALF=1.
    wr2 = 1;
    en2 = 1'b1;
    n = 0;
    while (done2_cnt == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("t7_bits", bits2, 2'b10);
    chk("t7_low", low2, 4);
    chk("t7_rises", rises2, 2);
    chk("t7_period_bad", period_bad2, 0);
    chk("t7_count", sent_count2, 1);
    chk("t7_done", done2_cnt, 1);

    chk("underflow", underflow, 0);
    chk("sdo_change_bad", sdo_bad, 0);
    chk("idle_pins_bad", idle_bad, 0);
    chk("done_timing_bad", done_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
